// File: rtl/game_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_pkg
// Description : Shared game package. Holds the game-flow state encoding and
//               the default level_number width, next to the existing screen
//               coordinate and RGB types used by the drawing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package game_sequencer_pkg;

    // Existing screen coordinate and colour types used by the drawing blocks
    typedef logic signed [10:0] coord_t;
    typedef logic [7:0]         rgb_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    // Default width of the level_number output
    localparam int LEVEL_WIDTH_DEFAULT = 2;

    // Game-flow states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEVEL_INIT = 3'd1,
        ST_PLAYING    = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_LEVEL_DONE = 3'd4,
        ST_GAME_OVER  = 3'd5,
        ST_WIN        = 3'd6
    } game_state_t;

endpackage : game_sequencer_pkg
`default_nettype wire

// File: rtl/game_sequencer_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Saturating startOfFrame pulse counter. i_clear zeroes the
//               count (a pulse in the clear cycle counts as the first one);
//               o_done is high once MAX_COUNT pulses have been seen.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int MAX_COUNT = 120
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_clear,
    input  logic i_sof,
    output logic o_done
);

    localparam int              c_CW  = $clog2(MAX_COUNT + 1);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_COUNT);
    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    logic [c_CW-1:0] r_count;

    // Count frame pulses, holding at MAX_COUNT until the next clear
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= i_sof ? c_ONE : '0;
        end else if (i_sof && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_done = (r_count == c_MAX);

endmodule : frame_timer
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Top-level game flow controller. Walks the game through
//               IDLE -> LEVEL_INIT -> PLAYING -> LEVEL_DONE/GAME_OVER/WIN,
//               re-initialises level objects, gates the frame strobe for the
//               gameplay blocks and tracks the current level.
//               Optional macro GAME_SEQUENCER_PAUSE_EN enables the pause
//               feature (pause_key toggles PLAYING <-> PAUSED); without it
//               pause_key has no effect and PAUSED is never entered.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int LEVEL_COUNT       = 3,
    parameter int LEVEL_WIDTH       = LEVEL_WIDTH_DEFAULT,
    parameter int TRANSITION_FRAMES = 120,
    parameter int INIT_CYCLES       = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   start_key,
    input  logic                   pause_key,
    input  logic                   player_dead,
    input  logic                   aliens_cleared,
    output logic                   game_enable,
    output logic                   level_resetN,
    output logic [LEVEL_WIDTH-1:0] level_number,
    output logic                   game_over,
    output logic                   game_won
);

    localparam int                     c_ICW        = $clog2(INIT_CYCLES + 1);
    localparam logic [c_ICW-1:0]       c_INIT_LAST  = c_ICW'(INIT_CYCLES - 1);
    localparam logic [c_ICW-1:0]       c_INIT_ONE   = c_ICW'(1);
    localparam logic [LEVEL_WIDTH-1:0] c_LAST_LEVEL = LEVEL_WIDTH'(LEVEL_COUNT - 1);
    localparam logic [LEVEL_WIDTH-1:0] c_LEVEL_ONE  = LEVEL_WIDTH'(1);

    game_state_t            r_state;
    logic [c_ICW-1:0]       r_init_cnt;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_game_enable;
    logic                   r_level_resetN;
    logic                   r_game_over;
    logic                   r_game_won;
    logic                   r_timer_clear;
    logic                   r_start_d;
    logic                   r_pause_d;

    logic                   w_start_edge;
    logic                   w_pause_edge;
    logic                   w_pause_req;
    logic                   w_timer_done;
    logic                   w_frames_done;

    // Key history for rising-edge detection; a held key gives one event
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_start_d <= 1'b0;
            r_pause_d <= 1'b0;
        end else begin
            r_start_d <= start_key;
            r_pause_d <= pause_key;
        end
    end

    assign w_start_edge = start_key & ~r_start_d;
    assign w_pause_edge = pause_key & ~r_pause_d;

`ifdef GAME_SEQUENCER_PAUSE_EN
    assign w_pause_req = w_pause_edge;
`else
    // Pause is compiled out: the key is observed but never acts
    assign w_pause_req = 1'b0 & w_pause_edge;
`endif

    frame_timer #(
        .MAX_COUNT (TRANSITION_FRAMES)
    ) u_frame_timer (
        .clk     (clk),
        .resetN  (resetN),
        .i_clear (r_timer_clear),
        .i_sof   (startOfFrame),
        .o_done  (w_timer_done)
    );

    // The timer still shows the previous state's count during the entry
    // cycle, so its done flag is ignored until the clear has taken effect.
    assign w_frames_done = w_timer_done & ~r_timer_clear;

    // Game-flow FSM; every output is registered alongside the state
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= ST_IDLE;
            r_init_cnt     <= '0;
            r_level        <= '0;
            r_game_enable  <= 1'b0;
            r_level_resetN <= 1'b0;
            r_game_over    <= 1'b0;
            r_game_won     <= 1'b0;
            r_timer_clear  <= 1'b0;
        end else begin
            r_timer_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_game_enable  <= 1'b0;
                    r_level_resetN <= 1'b1;
                    if (w_start_edge) begin
                        r_state        <= ST_LEVEL_INIT;
                        r_timer_clear  <= 1'b1;
                        r_level        <= '0;
                        r_level_resetN <= 1'b0;
                        r_init_cnt     <= '0;
                    end
                end

                ST_LEVEL_INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_state        <= ST_PLAYING;
                        r_timer_clear  <= 1'b1;
                        r_level_resetN <= 1'b1;
                        r_game_enable  <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + c_INIT_ONE;
                    end
                end

                ST_PLAYING: begin
                    // Death takes priority over a simultaneous clear
                    if (player_dead) begin
                        r_state       <= ST_GAME_OVER;
                        r_timer_clear <= 1'b1;
                        r_game_enable <= 1'b0;
                        r_game_over   <= 1'b1;
                    end else if (aliens_cleared) begin
                        r_state       <= ST_LEVEL_DONE;
                        r_timer_clear <= 1'b1;
                        r_game_enable <= 1'b0;
                    end else if (w_pause_req) begin
                        r_state       <= ST_PAUSED;
                        r_timer_clear <= 1'b1;
                        r_game_enable <= 1'b0;
                    end
                end

                ST_PAUSED: begin
                    if (w_pause_req) begin
                        r_state       <= ST_PLAYING;
                        r_timer_clear <= 1'b1;
                        r_game_enable <= 1'b1;
                    end
                end

                ST_LEVEL_DONE: begin
                    if (w_frames_done) begin
                        r_timer_clear <= 1'b1;
                        if (r_level == c_LAST_LEVEL) begin
                            r_state    <= ST_WIN;
                            r_game_won <= 1'b1;
                        end else begin
                            r_state        <= ST_LEVEL_INIT;
                            r_level        <= r_level + c_LEVEL_ONE;
                            r_level_resetN <= 1'b0;
                            r_init_cnt     <= '0;
                        end
                    end
                end

                ST_GAME_OVER, ST_WIN: begin
                    // Restart is locked out until the end screen has been shown
                    if (w_frames_done && w_start_edge) begin
                        r_state        <= ST_LEVEL_INIT;
                        r_timer_clear  <= 1'b1;
                        r_level        <= '0;
                        r_level_resetN <= 1'b0;
                        r_init_cnt     <= '0;
                        r_game_over    <= 1'b0;
                        r_game_won     <= 1'b0;
                    end
                end

                default: begin
                    r_state        <= ST_IDLE;
                    r_timer_clear  <= 1'b1;
                    r_game_enable  <= 1'b0;
                    r_level_resetN <= 1'b1;
                    r_game_over    <= 1'b0;
                    r_game_won     <= 1'b0;
                end
            endcase
        end
    end

    assign game_enable  = r_game_enable;
    assign level_resetN = r_level_resetN;
    assign level_number = r_level;
    assign game_over    = r_game_over;
    assign game_won     = r_game_won;

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Self-checking bench for game_sequencer. Plays randomised
//               games (random outcomes, frame spacing and ignored-input noise)
//               and compares the outputs with a level/outcome model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int LEVEL_COUNT       = 3;
    localparam int LEVEL_WIDTH       = 2;
    localparam int TRANSITION_FRAMES = 120;
    localparam int INIT_CYCLES       = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic start_key = 1'b0;
    logic pause_key = 1'b0;
    logic player_dead = 1'b0;
    logic aliens_cleared = 1'b0;
    logic game_enable;
    logic level_resetN;
    logic [LEVEL_WIDTH-1:0] level_number;
    logic game_over;
    logic game_won;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_level = 0;

    game_sequencer #(
        .LEVEL_COUNT       (LEVEL_COUNT),
        .LEVEL_WIDTH       (LEVEL_WIDTH),
        .TRANSITION_FRAMES (TRANSITION_FRAMES),
        .INIT_CYCLES       (INIT_CYCLES)
    ) u_dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .start_key      (start_key),
        .pause_key      (pause_key),
        .player_dead    (player_dead),
        .aliens_cleared (aliens_cleared),
        .game_enable    (game_enable),
        .level_resetN   (level_resetN),
        .level_number   (level_number),
        .game_over      (game_over),
        .game_won       (game_won)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input int en, input int lrst,
                            input int lvl, input int over, input int won);
        chk({tag, "_enable"},  game_enable,  en);
        chk({tag, "_lresetN"}, level_resetN, lrst);
        chk({tag, "_level"},   level_number, lvl);
        chk({tag, "_over"},    game_over,    over);
        chk({tag, "_won"},     game_won,     won);
    endtask

    // Single frame pulse, then gap cycles optionally carrying inputs that
    // must be ignored outside PLAYING
    task automatic frames(input int n, input bit noise);
        for (int k = 0; k < n; k++) begin
            player_dead = 1'b0;
            aliens_cleared = 1'b0;
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            for (int g = $urandom_range(3, 1); g > 0; g--) begin
                if (noise) begin
                    player_dead    = ($urandom_range(7, 0) == 0);
                    aliens_cleared = ($urandom_range(7, 0) == 0);
                end
                step();
            end
            player_dead = 1'b0;
            aliens_cleared = 1'b0;
        end
    endtask

    task automatic one_frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    // Watch a level initialisation sequence; start_key (if held by the
    // caller) is released after 'hold' cycles
    task automatic observe_init(input string tag, input int hold);
        int lows = 0;
        int falls = 0;
        int i = 0;
        bit prev = 1'b1;
        bit played = 1'b0;
        while (i < hold || (!played && i < hold + 60)) begin
            step();
            if (!level_resetN) lows++;
            if (prev && !level_resetN) falls++;
            prev = level_resetN;
            if (game_enable) played = 1'b1;
            i++;
            if (i == hold) start_key = 1'b0;
        end
        start_key = 1'b0;
        chk({tag, "_init_low"}, lows, INIT_CYCLES);
        chk({tag, "_init_seq"}, falls, 1);
        chk({tag, "_playing"}, played, 1);
        chk_outs(tag, 1, 1, exp_level, 0, 0);
    endtask

    // GAME_OVER / WIN screen: early start ignored, late start restarts
    task automatic end_screen(input string tag, input bit is_over);
        int early = $urandom_range(TRANSITION_FRAMES - 10, 20);
        frames(early, 1'b1);
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        step(3);
        chk_outs({tag, "_early_start"}, 0, 1, exp_level, is_over, !is_over);
        frames(TRANSITION_FRAMES - early - 1, 1'b1);
        step(3);
        chk_outs({tag, "_held"}, 0, 1, exp_level, is_over, !is_over);
        one_frame();
        step(2);
        exp_level = 0;
        start_key = 1'b1;
        observe_init({tag, "_restart"}, $urandom_range(6, 1));
    endtask

    task automatic pause_check();
`ifdef GAME_SEQUENCER_PAUSE_EN
        pause_key = 1'b1;
        step();
        pause_key = 1'b0;
        chk_outs("paused", 0, 1, exp_level, 0, 0);
        player_dead = 1'b1;
        aliens_cleared = 1'b1;
        start_key = 1'b1;
        step(3);
        player_dead = 1'b0;
        aliens_cleared = 1'b0;
        start_key = 1'b0;
        step(2);
        chk_outs("paused_ignore", 0, 1, exp_level, 0, 0);
        pause_key = 1'b1;
        step();
        pause_key = 1'b0;
        chk_outs("resumed", 1, 1, exp_level, 0, 0);
`else
        pause_key = 1'b1;
        step();
        pause_key = 1'b0;
        step();
        chk_outs("pause_ignored", 1, 1, exp_level, 0, 0);
`endif
    endtask

    // One level from PLAYING; mode 0 random, 1 clear, 2 dead+cleared together
    task automatic play_level(input int mode, output bit ended);
        int kind;
        bit dead;
        bit clr;
        ended = 1'b0;
        step($urandom_range(6, 1));
        chk("playing_enable", game_enable, 1);
        if ($urandom_range(3, 0) == 0) pause_check();
        kind = (mode == 1) ? 9 : (mode == 2) ? 2 : $urandom_range(9, 0);
        dead = (kind <= 2);
        clr  = (kind >= 2);
        player_dead = dead;
        aliens_cleared = clr;
        step();
        player_dead = 1'b0;
        aliens_cleared = 1'b0;
        chk_outs("level_end", 0, 1, exp_level, dead, 0);
        if (dead) begin
            end_screen("over", 1'b1);
            ended = 1'b1;
        end else begin
            frames(TRANSITION_FRAMES - 1, 1'b1);
            step(3);
            chk_outs("level_done_held", 0, 1, exp_level, 0, 0);
            one_frame();
            if (exp_level == LEVEL_COUNT - 1) begin
                step(2);
                chk_outs("win", 0, 1, exp_level, 0, 1);
                end_screen("win", 1'b0);
                ended = 1'b1;
            end else begin
                exp_level++;
                observe_init("next_level", 0);
            end
        end
    endtask

    initial begin
        bit ended;
        step(3);
        chk_outs("reset", 0, 0, 0, 0, 0);
        resetN = 1'b1;
        step();
        chk_outs("idle", 0, 1, 0, 0, 0);
        step(5);
        chk_outs("idle_wait", 0, 1, 0, 0, 0);

        exp_level = 0;
        start_key = 1'b1;
        observe_init("start_hold", 1000);

        for (int g = 0; g < 5; g++) begin
            ended = 1'b0;
            while (!ended) play_level((g == 0) ? 1 : (g == 1) ? 2 : 0, ended);
        end

        if ($urandom_range(1, 0) == 1) begin
            play_level(1, ended);
        end
`ifdef GAME_SEQUENCER_PAUSE_EN
        pause_key = 1'b1;
        step();
        pause_key = 1'b0;
        chk("pre_reset_paused", game_enable, 0);
`endif
        step(2);
        resetN = 1'b0;
        step();
        chk_outs("mid_reset", 0, 0, 0, 0, 0);
        step(2);
        resetN = 1'b1;
        step();
        chk_outs("after_reset", 0, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_game_sequencer
`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LEVEL_COUNT, default 3: number of levels per game.
REQ-002 Parameter LEVEL_WIDTH, default 2: width of level_number.
REQ-003 Parameter TRANSITION_FRAMES, default 120: frames held between levels and after game end.
REQ-004 Parameter INIT_CYCLES, default 4: clock cycles level_resetN is held low.
REQ-005 Port clk, input, 1: the single clock.
REQ-006 Port resetN, input, 1: asynchronous active-low reset.
REQ-007 Port startOfFrame, input, 1: one-cycle pulse per video frame.
REQ-008 Port start_key, input, 1: level-type pressed flag from the key decoder.
REQ-009 Port pause_key, input, 1: level-type pressed flag; used only with PAUSE_EN.
REQ-010 Port player_dead, input, 1: player block reports zero lives.
REQ-011 Port aliens_cleared, input, 1: every enemy in the level is destroyed.
REQ-012 Port game_enable, output, 1: qualifies startOfFrame for the player, enemy and missile blocks.
REQ-013 Port level_resetN, output, 1: active-low synchronous re-initialisation of the level objects.
REQ-014 Port level_number, output, LEVEL_WIDTH: current level, 0-based.
REQ-015 Port game_over, output, 1: the game ended with the player dead.
REQ-016 Port game_won, output, 1: all levels are cleared.

Function
REQ-017 States SHALL be IDLE, LEVEL_INIT, PLAYING, PAUSED, LEVEL_DONE, GAME_OVER and WIN.
REQ-018 All outputs SHALL be registered and change one clock after the causing event.
REQ-019 start_key and pause_key SHALL be rising-edge detected internally; a held key SHALL produce only one event.
REQ-020 IDLE: game_enable=0, level_resetN=1; a start edge SHALL clear level_number to 0 and go to LEVEL_INIT.
REQ-021 LEVEL_INIT: level_resetN SHALL be 0 for exactly INIT_CYCLES clocks, then the block SHALL go to PLAYING.
REQ-022 PLAYING: game_enable=1; player_dead SHALL go to GAME_OVER; aliens_cleared SHALL go to LEVEL_DONE.
REQ-023 If player_dead and aliens_cleared are asserted in the same cycle, player_dead SHALL win.
REQ-024 player_dead and aliens_cleared SHALL be ignored in every state except PLAYING.
REQ-025 LEVEL_DONE, GAME_OVER and WIN SHALL force game_enable=0 and count startOfFrame pulses from 0.
REQ-026 LEVEL_DONE, after TRANSITION_FRAMES pulses: if level_number==LEVEL_COUNT-1, go to WIN; otherwise increment level_number and go to LEVEL_INIT.
REQ-027 level_number SHALL never exceed LEVEL_COUNT-1 and SHALL never wrap.
REQ-028 GAME_OVER and WIN SHALL ignore start edges until TRANSITION_FRAMES pulses have elapsed; after that, a start edge SHALL clear level_number and go to LEVEL_INIT.
REQ-029 game_over SHALL be 1 only in GAME_OVER; game_won SHALL be 1 only in WIN.
REQ-030 The frame counter SHALL be sized from TRANSITION_FRAMES, SHALL saturate at that value, and SHALL clear on every state entry.

Reset
REQ-031 On resetN=0: state=IDLE, game_enable=0, level_resetN=0, level_number=0, game_over=0, game_won=0, counters=0, edge-detect history=0.
REQ-032 In the first clock after reset release, level_resetN SHALL go to 1.
REQ-033 Reset asserted mid-game SHALL abort immediately to these values, regardless of state.

Configuration
REQ-034 With macro GAME_SEQUENCER_PAUSE_EN defined, a pause edge in PLAYING SHALL go to PAUSED (game_enable=0), and a pause edge in PAUSED SHALL return to PLAYING.
REQ-035 In PAUSED, player_dead, aliens_cleared and start edges SHALL be ignored, and level_number SHALL be unchanged.
REQ-036 Without the macro, PAUSED SHALL be unreachable and pause_key SHALL be ignored.

Structure
REQ-037 The state enum typedef and the LEVEL_WIDTH default SHALL live in a shared game package; the existing coordinate/RGB typedefs SHALL remain unchanged.
REQ-038 One sub-module, frame_timer, SHALL implement the saturating startOfFrame counter with a clear input and a done output.

Verification
REQ-039 Reset, then start edge: level_resetN low for exactly 4 clocks, then game_enable=1, level_number=0.
REQ-040 In PLAYING, assert aliens_cleared: game_enable=0 for 120 startOfFrame pulses, then a LEVEL_INIT pulse, then level_number=1.
REQ-041 Clear levels 0, 1 and 2: game_won=1, and level_number stays at 2.
REQ-042 Assert player_dead and aliens_cleared in the same cycle: game_over=1 and level_number is unchanged. A start edge after 50 frames is ignored; a start edge after 120 frames restarts at level 0.
REQ-043 Hold start_key high for 1000 cycles in IDLE: exactly one LEVEL_INIT sequence.
REQ-044 With GAME_SEQUENCER_PAUSE_EN, a pause edge in PLAYING sets game_enable=0. player_dead asserted while paused is ignored. A second pause edge sets game_enable=1. Pulse resetN low mid-pause: all outputs return to their reset values.
